// File: rtl/switch_pkg.sv
// switch_pkg: shared definitions for the switch scanner.
//   - scan FSM state encodings
//   - debounce counter width
//   - event record layout (channel id + new level) and its packing helper
package switch_pkg;

    // Per-channel debounce counter width; STABLE_CNT-1 always fits.
    localparam int CNT_W = 4;

    // Event id field is sized for the largest supported bank (16 channels).
    localparam int EV_ID_W = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_t;

    typedef struct packed {
        logic [EV_ID_W-1:0] id;
        logic               press;
    } sw_event_t;

    localparam int EV_W = $bits(sw_event_t);

    function automatic sw_event_t pack_event(input logic [EV_ID_W-1:0] id,
                                             input logic               press);
        sw_event_t ev;
        ev.id    = id;
        ev.press = press;
        return ev;
    endfunction

endpackage

// File: rtl/switch_event_fifo.sv
// switch_event_fifo: small synchronous FIFO for switch events.
// Ports:
//   clk_i, rst_ni : clock, async active-low reset
//   push_i, din_i : write request and data
//   pop_i         : read request (ignored when empty)
//   dout_o        : head entry, valid while !empty_o
//   full_o        : no free entry
//   empty_o       : no entry stored
// A pop on a full FIFO frees the slot the same cycle, so a simultaneous
// push is accepted. DEPTH may be 1 (single holding register).
module switch_event_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 5
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    // Storage rounded up to the pointer range; pointers wrap at DEPTH-1.
    logic [(1<<AW)-1:0][W-1:0] mem_q;
    logic [AW-1:0]             wr_q, rd_q;
    logic [CW-1:0]             cnt_q;
    logic                      do_push, do_pop;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign dout_o  = mem_q[rd_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= nxt(wr_q);
            end
            if (do_pop) rd_q <= nxt(rd_q);
            if (do_push && !do_pop)      cnt_q <= cnt_q + CW'(1);
            else if (!do_push && do_pop) cnt_q <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/switch_scanner.sv
// switch_scanner: time-multiplexed debounce controller for a switch bank.
// One shared counter incrementer is stepped across the channels, one
// channel per clock, after every scan tick.
// Ports:
//   sys_clock, sys_reset_n : clock, async active-low reset
//   switch_in              : raw asynchronous switch inputs
//   switch_level           : debounced levels
//   event_valid/ready      : press/release event handshake
//   event_id, event_press  : changed channel, 1 = press, 0 = release
//   overflow, overflow_clr : sticky dropped-event flag and its clear
// Build option: define SWITCH_EVENT_FIFO_EN for a FIFO_DEPTH-entry event
// queue; otherwise events go through a single holding register.
module switch_scanner
    import switch_pkg::*;
#(
    parameter int N_SW       = 4,
    parameter int TICK_DIV   = 256,
    parameter int STABLE_CNT = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    sys_clock,
    input  logic                    sys_reset_n,
    input  logic [N_SW-1:0]         switch_in,
    output logic [N_SW-1:0]         switch_level,
    output logic                    event_valid,
    input  logic                    event_ready,
    output logic [$clog2(N_SW)-1:0] event_id,
    output logic                    event_press,
    output logic                    overflow,
    input  logic                    overflow_clr
);
    localparam int ID_W = $clog2(N_SW);
    localparam int PW   = $clog2(TICK_DIV);
`ifdef SWITCH_EVENT_FIFO_EN
    localparam int Q_DEPTH = FIFO_DEPTH;
`else
    localparam int Q_DEPTH = 1;
`endif

    // A scan must finish before the next tick can start one.
    if (TICK_DIV < N_SW + 2) begin : g_bad_tick_div
        $error("switch_scanner: TICK_DIV must be >= N_SW+2");
    end
    if (N_SW < 2 || N_SW > 16) begin : g_bad_n_sw
        $error("switch_scanner: N_SW must be 2..16");
    end
    if (STABLE_CNT < 2 || STABLE_CNT > 15) begin : g_bad_stable
        $error("switch_scanner: STABLE_CNT must be 2..15");
    end

    logic [N_SW-1:0]             sync1_q, sync_q;
    logic [PW-1:0]               presc_q;
    logic                        tick;
    scan_state_t                 state_q;
    logic [ID_W-1:0]             ch_q;
    logic [N_SW-1:0][CNT_W-1:0]  cnt_q;
    logic [N_SW-1:0]             level_q;
    logic                        ovf_q;

    logic [CNT_W-1:0]            cnt_cur, cnt_inc;
    logic                        differ, settle, ev_push, pop, drop;
    sw_event_t                   ev_din, ev_out;
    logic                        q_full, q_empty;

    // Synchronizer and scan prescaler.
    always_ff @(posedge sys_clock or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            sync1_q <= '0;
            sync_q  <= '0;
            presc_q <= '0;
        end else begin
            sync1_q <= switch_in;
            sync_q  <= sync1_q;
            presc_q <= tick ? '0 : presc_q + PW'(1);
        end
    end

    assign tick = (presc_q == PW'(TICK_DIV - 1));

    // Shared incrementer: operates on the channel currently selected by ch_q.
    always_comb begin
        cnt_cur = cnt_q[ch_q];
        cnt_inc = cnt_cur + CNT_W'(1);
        differ  = sync_q[ch_q] ^ level_q[ch_q];
        settle  = differ && (cnt_cur == CNT_W'(STABLE_CNT - 1));
        ev_push = (state_q == ST_SCAN) && settle;
        ev_din  = pack_event(EV_ID_W'(ch_q), ~level_q[ch_q]);
    end

    assign pop  = event_valid && event_ready;
    assign drop = ev_push && q_full && !pop;

    // Scan FSM with the per-channel counters, levels and overflow flag.
    always_ff @(posedge sys_clock or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            state_q <= ST_IDLE;
            ch_q    <= '0;
            cnt_q   <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            // A new drop takes priority over a clear in the same cycle.
            if (drop)              ovf_q <= 1'b1;
            else if (overflow_clr) ovf_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (tick) begin
                        state_q <= ST_SCAN;
                        ch_q    <= '0;
                    end
                end
                ST_SCAN: begin
                    if (!differ) begin
                        cnt_q[ch_q] <= '0;
                    end else if (settle) begin
                        cnt_q[ch_q]   <= '0;
                        level_q[ch_q] <= ~level_q[ch_q];
                    end else begin
                        cnt_q[ch_q] <= cnt_inc;
                    end
                    if (ch_q == ID_W'(N_SW - 1)) state_q <= ST_IDLE;
                    else                         ch_q    <= ch_q + ID_W'(1);
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    switch_event_fifo #(
        .DEPTH (Q_DEPTH),
        .W     (EV_W)
    ) u_fifo (
        .clk_i   (sys_clock),
        .rst_ni  (sys_reset_n),
        .push_i  (ev_push),
        .din_i   (ev_din),
        .pop_i   (pop),
        .dout_o  (ev_out),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    // Id bits above the bank size are always zero.
    if (ID_W < EV_ID_W) begin : g_id_pad
        logic unused_id_hi;
        assign unused_id_hi = |ev_out.id[EV_ID_W-1:ID_W];
    end

    assign switch_level = level_q;
    assign overflow     = ovf_q;
    assign event_valid  = !q_empty;
    assign event_id     = ev_out.id[ID_W-1:0];
    assign event_press  = ev_out.press;

endmodule

// File: tb/tb_switch_scanner.sv
module tb_switch_scanner;
    localparam int N  = 4;
    localparam int TD = 16;
    localparam int SC = 4;
    localparam int FD = 4;
`ifdef SWITCH_EVENT_FIFO_EN
    localparam int MDEPTH = FD;
`else
    localparam int MDEPTH = 1;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] sw = '0;
    logic [N-1:0] level;
    logic         ev_valid;
    logic         ev_ready = 1'b0;
    logic [1:0]   ev_id;
    logic         ev_press;
    logic         ovf;
    logic         ovf_clr = 1'b0;

    switch_scanner #(
        .N_SW(N), .TICK_DIV(TD), .STABLE_CNT(SC), .FIFO_DEPTH(FD)
    ) dut (
        .sys_clock    (clk),
        .sys_reset_n  (rst_n),
        .switch_in    (sw),
        .switch_level (level),
        .event_valid  (ev_valid),
        .event_ready  (ev_ready),
        .event_id     (ev_id),
        .event_press  (ev_press),
        .overflow     (ovf),
        .overflow_clr (ovf_clr)
    );

    always #5 clk = ~clk;

    // Clock edges since reset release; phase = cyc % TD tracks the scan schedule.
    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    typedef struct {
        int id;
        bit press;
    } ev_t;

    ev_t    exp_q[$];
    int     errors = 0;
    int     checks = 0;

    // Reference model: debounced level and run length of differing samples.
    bit [N-1:0] m_lvl;
    int         m_run[N];
    bit         m_ovf;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_lvl = '0;
        m_ovf = 0;
        for (int c = 0; c < N; c++) m_run[c] = 0;
        exp_q.delete();
    endtask

    // One scan: a level flips after SC consecutive differing samples. While
    // the consumer is not draining, events beyond the queue capacity are lost.
    task automatic model_scan(input logic [N-1:0] s, input bit draining);
        for (int c = 0; c < N; c++) begin
            if (s[c] != m_lvl[c]) begin
                m_run[c]++;
                if (m_run[c] == SC) begin
                    m_lvl[c] = ~m_lvl[c];
                    m_run[c] = 0;
                    if (draining || exp_q.size() < MDEPTH)
                        exp_q.push_back('{c, m_lvl[c]});
                    else
                        m_ovf = 1;
                end
            end else begin
                m_run[c] = 0;
            end
        end
    endtask

    task automatic wait_phase(input int p);
        do @(negedge clk); while ((cyc % TD) != p);
    endtask

    // One scan period. At phase 8 the previous scan is done and drained,
    // so state is checked there and the next scan's inputs are applied.
    // 'late' raises ready just before the first channel is evaluated.
    task automatic period(input logic [N-1:0] s, input bit rdy,
                          input bit late, input bit clr);
        wait_phase(8);
        check("switch_level", int'(level), int'(m_lvl));
        check("overflow", int'(ovf), int'(m_ovf));
        check("event_valid", int'(ev_valid), int'(exp_q.size() != 0));
        sw       = s;
        ev_ready = late ? 1'b0 : rdy;
        if (clr) begin
            ovf_clr = 1'b1;
            m_ovf   = 0;
        end
        model_scan(s, rdy || late);
        if (clr) begin
            @(negedge clk);
            ovf_clr = 1'b0;
        end
        if (late) begin
            wait_phase(0);
            ev_ready = 1'b1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_level"}, int'(level), 0);
        check({tag, "_valid"}, int'(ev_valid), 0);
        check({tag, "_id"}, int'(ev_id), 0);
        check({tag, "_press"}, int'(ev_press), 0);
        check({tag, "_overflow"}, int'(ovf), 0);
    endtask

    // Scoreboard monitor: every handshake pops the oldest expected event.
    initial begin : monitor
        ev_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && ev_valid && ev_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL event_unexpected: got id=%0d press=%0d expected none",
                             ev_id, ev_press);
                end else begin
                    e = exp_q.pop_front();
                    check("event_id", int'(ev_id), e.id);
                    check("event_press", int'(ev_press), int'(e.press));
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation still running at t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [N-1:0] rs;
        bit           r_rdy, r_late, r_clr;

        // Reset with random inputs.
        sw = N'($urandom);
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        model_reset();
        rst_n = 1'b1;

        // Idle, then a clean press and release on channel 1.
        repeat (2) period('0, 1, 0, 0);
        repeat (5) period(4'b0010, 1, 0, 0);
        repeat (5) period(4'b0000, 1, 0, 0);

        // Bounce on channel 0 every tick, then settle low.
        for (int i = 0; i < 10; i++) period((i % 2 == 0) ? 4'b0001 : 4'b0000, 1, 0, 0);
        repeat (5) period(4'b0000, 1, 0, 0);

        // Overflow: fill with presses, drop releases, drain, clear.
        repeat (4) period(4'b1111, 0, 0, 0);
        repeat (4) period(4'b0000, 0, 0, 0);
        repeat (2) period(4'b0000, 1, 0, 0);
        period(4'b0000, 1, 0, 1);
        period(4'b0000, 1, 0, 0);

        // Full queue, ready raised right as the next scan pushes.
        repeat (4) period(4'b1111, 0, 0, 0);
        period(4'b0000, 0, 0, 1);
        repeat (2) period(4'b0000, 0, 0, 0);
        period(4'b0000, 1, 1, 0);
        repeat (2) period(4'b0000, 1, 0, 0);

        // Two presses in one scan with the consumer stalled.
        repeat (4) period(4'b0011, 0, 0, 0);
        repeat (2) period(4'b0011, 1, 0, 1);
        repeat (5) period(4'b0000, 1, 0, 0);

        // Reset pulsed in the middle of a scan.
        repeat (4) period(4'b1111, 0, 0, 0);
        wait_phase(2);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) period(4'b1111, 1, 0, 0);
        repeat (5) period(4'b0000, 1, 0, 0);

        // Randomized traffic.
        rs = '0;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(2) == 0) rs = N'($urandom);
            r_rdy  = ($urandom_range(1) == 1);
            r_late = r_rdy && ($urandom_range(4) == 0);
            r_clr  = ($urandom_range(7) == 0);
            period(rs, r_rdy, r_late, r_clr);
        end

        // Drain everything and confirm nothing is left outstanding.
        repeat (3) period(rs, 1, 0, 1);
        wait_phase(8);
        check("final_level", int'(level), int'(m_lvl));
        check("final_valid", int'(ev_valid), 0);
        check("final_queue", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/switch_scanner.md
# switch_scanner

Time-multiplexed debounce controller for the board's switch bank. A single shared debounce incrementer is scheduled across `N_SW` raw switch inputs, one channel per clock on each scan tick. The block publishes stable switch levels and queues press/release events for the CPU-side consumer over a valid/ready handshake. It replaces one free-running debouncer per switch on the board-test and CPU I/O paths.

## Interface
- `N_SW`, 4: number of switch channels (2..16).
- `TICK_DIV`, 256: clocks per scan tick. Must be ≥ `N_SW`+2; an elaboration-time check enforces this.
- `STABLE_CNT`, 8: consecutive differing samples required to accept a level change (2..15).
- `FIFO_DEPTH`, 4: event queue depth (power of two; used only when the FIFO is compiled in).

- `sys_clock`  in  1: single clock, rising edge.
- `sys_reset_n`  in  1: asynchronous, active-low reset.
- `switch_in`  in  N_SW: raw, asynchronous switch inputs.
- `switch_level`  out  N_SW: debounced levels.
- `event_valid`  out  1: an event is available.
- `event_ready`  in  1: consumer accepts the event.
- `event_id`  out  $clog2(N_SW): channel that changed.
- `event_press`  out  1: 1 = rising (press), 0 = falling (release).
- `overflow`  out  1: sticky flag, set when an event was dropped.
- `overflow_clr`  in  1: clears `overflow`.

## Operation
- Each `switch_in` bit passes through a 2-flop synchronizer, giving `sync[ch]`.
- A prescaler counts 0..`TICK_DIV`-1. At the wrap it pulses `tick` for one cycle.
- FSM, states IDLE and SCAN:
  - IDLE → SCAN on `tick`, with `ch`=0.
  - SCAN processes one channel per cycle. At `ch`=`N_SW`-1 it returns to IDLE.
- Per-channel processing in SCAN:
  - `sync[ch]` == `switch_level[ch]`: `cnt[ch]` is cleared.
  - Differs and `cnt[ch]` < `STABLE_CNT`-1: `cnt[ch]` increments.
  - Differs and `cnt[ch]` == `STABLE_CNT`-1: toggle `switch_level[ch]`, clear `cnt[ch]`, push event {`ch`, new level}.
- `cnt` is 4 bits per channel and saturates by construction; there is no wrap-around.
- Push into a full queue: the event is dropped and `overflow` is set.
- Pop and push on the same cycle with the queue full: the pop is honoured first, so the push is accepted.
- `overflow_clr` and a new overflow on the same cycle: the set wins.
- Events leave in scan order, so the lower `ch` is first within one scan.

## Timing
- Reset values:
  - `switch_level`, `event_valid`, `event_id`, `event_press` and `overflow` are all 0.
  - Prescaler, all `cnt`, FSM (IDLE) and queue pointers are cleared.
- Reset asserted mid-scan or mid-handshake: everything clears immediately and queued events are lost.
- Channel k is evaluated k+1 cycles after `tick`.
- `switch_level[k]` updates on the `STABLE_CNT`-th consecutive tick whose sample differs, at the cycle after channel k is evaluated.
- `event_valid` rises the cycle after the push.
- The data outputs hold stable while `event_valid`=1 and `event_ready`=0.
- A pop occurs on a cycle where `event_valid`&&`event_ready`.
- The next entry appears the following cycle.

## Configuration
- `SWITCH_EVENT_FIFO_EN` defined:
  - The queue is `FIFO_DEPTH` entries.
  - `event_valid` is the not-empty flag.
- `SWITCH_EVENT_FIFO_EN` undefined:
  - The queue is a single holding register.
  - A push while it is occupied, and not popping that cycle, is dropped and sets `overflow`.
  - `FIFO_DEPTH` is ignored.

## Structure
- Shared package `switch_pkg` holds:
  - FSM state encodings (`ST_IDLE`, `ST_SCAN`);
  - the event field widths and the event packing;
  - the `cnt` width constant.
- Sub-module `switch_event_fifo`:
  - synchronous FIFO with push/pop/full/empty;
  - built at depth 1 when the macro is off.
- Synchronizer, prescaler, FSM and the shared incrementer live in `switch_scanner`.

## Test plan
Parameters `N_SW`=4, `TICK_DIV`=16, `STABLE_CNT`=4, macro on unless stated.
- Reset: hold `sys_reset_n`=0 with random `switch_in` → all outputs 0. After release, no event until 4 ticks of a differing input.
- Clean press: `switch_in`=4'b0010 held → after the 4th tick `switch_level`=4'b0010 and exactly one event {id=1, press=1}. Release → one event {id=1, press=0}.
- Bounce: toggle `switch_in[0]` every tick for 10 ticks, then hold 0 → no level change, no event, `cnt[0]` never reaches 3.
- Overflow: `event_ready`=0, press all four switches → queue holds ids 0,1,2,3 in order. Release all → 4 events dropped, `overflow`=1. Then `event_ready`=1 → drains 0,1,2,3 press=1. `overflow_clr` → 0.
- Full-queue pop+push: fill the queue, then `event_ready`=1 on the push cycle → push accepted, `overflow` stays 0.
- Macro off / reset mid-scan:
  - Macro off, two presses in one scan with `event_ready`=0 → only id 0 delivered, `overflow`=1.
  - `sys_reset_n` pulsed during SCAN → everything 0, FSM IDLE.
